// File: rtl/rgb2ycbcr_axis_pipe.sv
// RGB -> YCbCr (BT.601 full range, 8-bit fractional coefficients) on AXI4-Stream video, 3 pipeline stages.
// Optional macro YCBCR_422_EN adds the cfg_422 port and 4:2:2 chroma decimation in the output stage.
module rgb2ycbcr_axis_pipe #(
    parameter int IN_W  = 8,
    parameter int IN_FW = 10,
    parameter int S_W   = 32,
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
`ifdef YCBCR_422_EN
    input  logic               cfg_422,
`endif
    input  logic [S_W-1:0]     s_axis_video_tdata,
    input  logic               s_axis_video_tvalid,
    output logic               s_axis_video_tready,
    input  logic               s_axis_video_tlast,
    input  logic               s_axis_video_tuser,
    output logic [3*OUT_W-1:0] m_axis_video_tdata,
    output logic               m_axis_video_tvalid,
    input  logic               m_axis_video_tready,
    output logic               m_axis_video_tlast,
    output logic               m_axis_video_tuser
);
    localparam int PW = IN_W + 8;
    localparam int SW = IN_W + 10;
    localparam int SH = OUT_W - IN_W;
    localparam logic signed [SW-1:0] RND  = SW'(128);
    localparam logic signed [SW-1:0] HALF = SW'((1 << (IN_W - 1)) << 8);

    // Valid/ready: a beat moves on a rising clk edge when valid and ready are both high; a stage
    // holds its payload while valid and not accepted; ready never depends on s_axis_video_tvalid.
    logic v1, v2, v3, rdy1, rdy2, rdy3;
    assign rdy3 = !v3 || m_axis_video_tready;
    assign rdy2 = !v2 || rdy3;
    assign rdy1 = !v1 || rdy2;
    assign s_axis_video_tready = rdy1 && !rst;
    assign m_axis_video_tvalid = v3;

    logic [IN_W-1:0] in_g, in_b, in_r;
    logic            unused_in;
    assign in_g = s_axis_video_tdata[0*IN_FW+IN_FW-1 -: IN_W];
    assign in_b = s_axis_video_tdata[1*IN_FW+IN_FW-1 -: IN_W];
    assign in_r = s_axis_video_tdata[2*IN_FW+IN_FW-1 -: IN_W];
    assign unused_in = ^s_axis_video_tdata;

    // S1: nine coefficient products, all non-negative; signs are applied in S2.
    logic [PW-1:0] p_yr, p_yg, p_yb, p_br, p_bg, p_bb, p_rr, p_rg, p_rb;
    logic          s1_last, s1_user;
`ifdef YCBCR_422_EN
    logic          mode_q, s1_m;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;  s1_last <= 1'b0;  s1_user <= 1'b0;
            p_yr <= '0;  p_yg <= '0;  p_yb <= '0;
            p_br <= '0;  p_bg <= '0;  p_bb <= '0;
            p_rr <= '0;  p_rg <= '0;  p_rb <= '0;
`ifdef YCBCR_422_EN
            mode_q <= 1'b0;  s1_m <= 1'b0;
`endif
        end else if (rdy1) begin
            v1 <= s_axis_video_tvalid;
            if (s_axis_video_tvalid) begin
                p_yr <= PW'(in_r) * PW'(77);   p_yg <= PW'(in_g) * PW'(150);  p_yb <= PW'(in_b) * PW'(29);
                p_br <= PW'(in_r) * PW'(43);   p_bg <= PW'(in_g) * PW'(85);   p_bb <= PW'(in_b) * PW'(128);
                p_rr <= PW'(in_r) * PW'(128);  p_rg <= PW'(in_g) * PW'(107);  p_rb <= PW'(in_b) * PW'(21);
                s1_last <= s_axis_video_tlast;
                s1_user <= s_axis_video_tuser;
`ifdef YCBCR_422_EN
                // Chroma mode is latched at start of frame and carried with each pixel.
                s1_m <= s_axis_video_tuser ? cfg_422 : mode_q;
                if (s_axis_video_tuser) mode_q <= cfg_422;
`endif
            end
        end
    end

    logic signed [SW-1:0] y_sum, cb_sum, cr_sum;
    assign y_sum  = $signed({2'b00, p_yr}) + $signed({2'b00, p_yg}) + $signed({2'b00, p_yb}) + RND;
    assign cb_sum = HALF + RND + $signed({2'b00, p_bb}) - $signed({2'b00, p_br}) - $signed({2'b00, p_bg});
    assign cr_sum = HALF + RND + $signed({2'b00, p_rr}) - $signed({2'b00, p_rg}) - $signed({2'b00, p_rb});

    function automatic logic [IN_W-1:0] clamp_pix(input logic signed [SW-1:0] v);
        logic signed [SW-1:0] q;
        q = v >>> 8;
        if (q[SW-1])             return '0;
        else if (|q[SW-2:IN_W])  return '1;
        else                     return q[IN_W-1:0];
    endfunction

    function automatic logic [OUT_W-1:0] align(input logic [IN_W-1:0] c);
        return OUT_W'(c) << SH;
    endfunction

    // S2: rounded, clamped components.
    logic [IN_W-1:0] s2_y, s2_cb, s2_cr;
    logic            s2_last, s2_user;
`ifdef YCBCR_422_EN
    logic            s2_m;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0;  s2_y <= '0;  s2_cb <= '0;  s2_cr <= '0;
            s2_last <= 1'b0;  s2_user <= 1'b0;
`ifdef YCBCR_422_EN
            s2_m <= 1'b0;
`endif
        end else if (rdy2) begin
            v2 <= v1;
            if (v1) begin
                s2_y    <= clamp_pix(y_sum);
                s2_cb   <= clamp_pix(cb_sum);
                s2_cr   <= clamp_pix(cr_sum);
                s2_last <= s1_last;
                s2_user <= s1_user;
`ifdef YCBCR_422_EN
                s2_m    <= s1_m;
`endif
            end
        end
    end

    logic [3*OUT_W-1:0] out_d;
`ifdef YCBCR_422_EN
    typedef enum logic {PH_EVEN = 1'b0, PH_ODD = 1'b1} phase_t;
    phase_t          phase_q, phase_d, phase_cur;
    logic [IN_W-1:0] cr_hold_q;
    logic            hold_cr;

    always_comb begin
        phase_d   = phase_q;
        hold_cr   = 1'b0;
        phase_cur = s2_user ? PH_EVEN : phase_q;
        out_d     = {align(s2_cr), align(s2_cb), align(s2_y)};
        if (s2_m) begin
            if (phase_cur == PH_EVEN) out_d = {OUT_W'(0), align(s2_cb), align(s2_y)};
            else                      out_d = {OUT_W'(0), align(cr_hold_q), align(s2_y)};
        end
        // Phase advances only when a beat actually enters the output register.
        if (v2 && rdy3) begin
            if (!s2_m || s2_last || phase_cur == PH_ODD) phase_d = PH_EVEN;
            else                                         phase_d = PH_ODD;
            hold_cr = s2_m && (phase_cur == PH_EVEN);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= PH_EVEN;
            cr_hold_q <= '0;
        end else begin
            phase_q <= phase_d;
            if (hold_cr) cr_hold_q <= s2_cr;
        end
    end
`else
    assign out_d = {align(s2_cr), align(s2_cb), align(s2_y)};
`endif

    // S3: output register, frozen while the sink stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v3                 <= 1'b0;
            m_axis_video_tdata <= '0;
            m_axis_video_tlast <= 1'b0;
            m_axis_video_tuser <= 1'b0;
        end else if (rdy3) begin
            v3 <= v2;
            if (v2) begin
                m_axis_video_tdata <= out_d;
                m_axis_video_tlast <= s2_last;
                m_axis_video_tuser <= s2_user;
            end
        end
    end
endmodule
